onchip_mem_stream_loader: RTL and testbench
===========================================

// Module: onchip_mem_stream_loader
// PURPOSE
//  Upstream stage of the 32-bit single-port on-chip program/data RAM (13-bit word address, 4 byte lanes).
//  Accepts a byte stream (e.g. UART/JTAG boot path), packs it little-endian into 32-bit words.
//  Drives the RAM's write port directly with address/byteenable/chipselect/write/clken.
//  Writes complete in one cycle; the RAM has no waitrequest.
// PARAMETERS
//  ADDR_W  13    RAM word-address width
//  DEPTH   6500  RAM words; last legal address is DEPTH-1
// PORTS
//  clk             in   1       single clock
//  reset_n         in   1       asynchronous reset, active low
//  start           in   1       begin load; sampled only in IDLE
//  base_addr       in   ADDR_W  first word address, latched on accepted start
//  in_data         in   8       stream byte
//  in_valid        in   1       in_data valid
//  in_eop          in   1       qualifies in_data as last byte (meaningful only with in_valid)
//  in_ready        out  1       byte accepted when in_valid & in_ready
//  mem_address     out  ADDR_W  RAM word address
//  mem_byteenable  out  4       lanes written
//  mem_writedata   out  32      packed word
//  mem_chipselect  out  1       asserted with mem_write
//  mem_write       out  1       one-cycle write strobe
//  mem_clken       out  1       constant 1 out of reset
//  busy            out  1       high in LOAD/FLUSH
//  done            out  1       one-cycle pulse at end of load
//  overflow        out  1       sticky until next accepted start: bytes dropped past DEPTH-1
//  word_count      out  ADDR_W+1  writes actually issued this load
// BEHAVIOUR
//  Reset: all outputs 0 except mem_clken=1 after reset release; state IDLE; partial word discarded.
//  States:
//   IDLE -start-> LOAD (latch base_addr; clear word_count, overflow, lane ptr).
//   LOAD -accept eop-> FLUSH; FLUSH -1 cycle-> DONE; DONE -1 cycle-> IDLE (done=1 in DONE).
//  start outside IDLE ignored.
//  in_ready=1 only in LOAD; bytes offered in IDLE/FLUSH/DONE not accepted; in_eop without in_valid ignored.
//  Packing: byte k of a word goes to lane k (bits 8k+7:8k); lane ptr 0..3 wraps to 0 after lane 3.
//  Write issue: on acceptance of a lane-3 byte or an eop byte, registered write the following cycle:
//   mem_write=mem_chipselect=1 for exactly one cycle.
//   mem_byteenable = filled lanes (eop on lane 1 -> 4'b0011); unfilled lanes of writedata = 0.
//   Address then increments.
//  Throughput: 1 byte/cycle sustained, no bubbles; the next word packs while the previous write is issued.
//  FLUSH exists so the final write lands before done; done is never coincident with mem_write.
//  Bounds: a word whose address would be >= DEPTH is not written (mem_write stays 0).
//   overflow set; remaining bytes accepted and dropped until eop. No address wrap-around.
//  word_count increments per issued write only; holds its value until next start.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   extra output csum[15:0], the mod-2^16 sum of every accepted byte (dropped ones included).
//   csum cleared on start; valid when done pulses.
//  Undefined: port absent, no adder logic.
// STRUCTURE
//  Shared package onchip_loader_pkg: state enum {IDLE,LOAD,FLUSH,DONE}, LANES=4, byte-lane constants.
//  One sub-module: onchip_loader_packer (lane ptr, word assembly, byteenable, word-ready flag).
//  Top holds FSM, address/count, bounds check, optional checksum.
// TESTING
//  1. base 0x010, bytes 01..08, eop on 08 -> writes @0x010 0x04030201 be F, @0x011 0x08070605 be F;
//     done 1 cycle after last write; word_count 2.
//  2. base 0, bytes 01..05 eop on 05 -> second write @0x001 data 0x00000005 be 0x1; word_count 2.
//  3. base 6498, 12 bytes -> writes @6498, @6499 only; overflow=1; word_count 2; all 12 bytes accepted.
//  4. start pulsed mid-load with base 0x100 -> ignored; addresses continue from original base.
//  5. reset_n low after 6 bytes -> all outputs 0 immediately, no further writes.
//     New start at 0x020, 4 bytes -> single write @0x020.
//  6. LOADER_CHECKSUM_EN: bytes FF,FF,FF,FF eop -> csum 0x03FC at done; next start -> csum 0.

Source files
------------

// File: rtl/onchip_mem_stream_loader_pkg.sv
// Shared types and constants for the byte-stream to on-chip RAM loader.
package onchip_loader_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned CSUM_W = 16;

  localparam logic [LANE_W-1:0] LANE_FIRST = LANE_W'(0);
  localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One assembled RAM word with its lane enables.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  be;
  } word_t;

endpackage

// File: rtl/onchip_mem_stream_loader_if.sv
// Byte-stream input bundle and RAM write-port bundle used by the loader.
interface onchip_loader_stream_if;
  import onchip_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_eop;
  logic              in_ready;

  modport master (output in_data, output in_valid, output in_eop, input  in_ready);
  modport slave  (input  in_data, input  in_valid, input  in_eop, output in_ready);
endinterface

interface onchip_loader_mem_if #(parameter int unsigned ADDR_W = 13);
  import onchip_loader_pkg::*;

  logic [ADDR_W-1:0] mem_address;
  logic [LANES-1:0]  mem_byteenable;
  logic [WORD_W-1:0] mem_writedata;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_clken;

  modport master (output mem_address, output mem_byteenable, output mem_writedata,
                  output mem_chipselect, output mem_write, output mem_clken);
  modport slave  (input  mem_address, input  mem_byteenable, input  mem_writedata,
                  input  mem_chipselect, input  mem_write, input  mem_clken);
endinterface

// File: rtl/onchip_mem_stream_loader_packer.sv
// Little-endian byte-to-word packer: lane pointer, partial word and completed-word flag.
module onchip_loader_packer
  import onchip_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] data,
  input  logic              eop,
  output logic              word_ready_c,
  output word_t             word_c
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] merged_c;

  // Completed word includes the byte being accepted this cycle.
  always_comb begin
    merged_c     = data_q | (WORD_W'(data) << (5'(lane_q) << 3));
    word_ready_c = accept & (eop | (lane_q == LANE_LAST));
    word_c.data  = merged_c;
    word_c.be    = LANES'((5'd2 << lane_q) - 5'd1);
  end

  always_comb begin
    lane_d = lane_q;
    data_d = data_q;
    if (clear) begin
      lane_d = LANE_FIRST;
      data_d = '0;
    end else if (accept) begin
      if (word_ready_c) begin
        lane_d = LANE_FIRST;
        data_d = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
        data_d = merged_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= LANE_FIRST;
      data_q <= '0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// Byte-stream loader into the single-port on-chip RAM: FSM, addressing, bounds, counters.
// Optional running byte checksum output when LOADER_CHECKSUM_EN is defined.
module onchip_mem_stream_loader
  import onchip_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 6500
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  onchip_loader_stream_if.slave s,
  onchip_loader_mem_if.master   m,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W:0]     word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0]   csum
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] LOAD  = ST_LOAD;
  localparam logic [1:0] FLUSH = ST_FLUSH;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_data_q, mem_data_d;
  logic [LANES-1:0]  mem_be_q, mem_be_d;
  logic              mem_clken_q;

  logic  start_ok_c;
  logic  accept_c;
  logic  word_ready_c;
  word_t word_c;

  assign start_ok_c = start & (state_q == IDLE);
  assign accept_c   = s.in_valid & in_ready_q;

  onchip_loader_packer u_packer (
    .clk          (clk),
    .rst_n        (reset_n),
    .clear        (start_ok_c),
    .accept       (accept_c),
    .data         (s.in_data),
    .eop          (s.in_eop),
    .word_ready_c (word_ready_c),
    .word_c       (word_c)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_be_d    = mem_be_q;

    case (state_q)
      IDLE: if (start) begin
        state_d    = LOAD;
        addr_d     = CNT_W'(base_addr);
        count_d    = '0;
        overflow_d = 1'b0;
      end
      LOAD:    if (accept_c && s.in_eop) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Words at or past DEPTH are dropped; the address never advances past DEPTH.
    if (word_ready_c) begin
      if (addr_q < DEPTH_C) begin
        mem_write_d = 1'b1;
        mem_addr_d  = addr_q[ADDR_W-1:0];
        mem_data_d  = word_c.data;
        mem_be_d    = word_c.be;
        addr_d      = addr_q + CNT_W'(1);
        count_d     = count_q + CNT_W'(1);
      end else begin
        overflow_d  = 1'b1;
      end
    end

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d == LOAD) || (state_d == FLUSH);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_be_q    <= '0;
      mem_clken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_be_q    <= mem_be_d;
      mem_clken_q <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;

  // Sums every accepted byte, including those dropped by the bounds check.
  always_comb begin
    csum_d = csum_q;
    if (start_ok_c)    csum_d = '0;
    else if (accept_c) csum_d = csum_q + CSUM_W'(s.in_data);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

  assign s.in_ready       = in_ready_q;
  assign m.mem_address    = mem_addr_q;
  assign m.mem_byteenable = mem_be_q;
  assign m.mem_writedata  = mem_data_q;
  assign m.mem_chipselect = mem_write_q;
  assign m.mem_write      = mem_write_q;
  assign m.mem_clken      = mem_clken_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign overflow         = overflow_q;
  assign word_count       = count_q;

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Scoreboard bench for onchip_mem_stream_loader: directed loads, write and done-time checks.
module tb_onchip_mem_stream_loader;
  import onchip_loader_pkg::*;

  localparam int unsigned AW = 13;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [AW-1:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
  typedef struct { logic [AW:0] wc; logic ov; logic [15:0] cs; bit lat; } dn_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, overflow;
  logic [AW:0]   word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]   csum;
`endif

  onchip_loader_stream_if             s_if ();
  onchip_loader_mem_if #(.ADDR_W(AW)) m_if ();

  onchip_mem_stream_loader #(.ADDR_W(AW), .DEPTH(6500)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .s          (s_if),
    .m          (m_if),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
`ifdef LOADER_CHECKSUM_EN
    ,
    .csum       (csum)
`endif
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_wr_cyc = -10;
  wr_t exp_wr[$];
  dn_t exp_dn[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT writes or pulses done.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_if.mem_write) begin
        last_wr_cyc = cyc;
        chk("chipselect_with_write", 32'(m_if.mem_chipselect), 32'd1);
        if (exp_wr.size() == 0) begin
          chk("unexpected_write_addr", 32'(m_if.mem_address), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("write_addr", 32'(m_if.mem_address), 32'(e.a));
          chk("write_data", m_if.mem_writedata, e.d);
          chk("write_be", 32'(m_if.mem_byteenable), 32'(e.be));
        end
      end
      if (done) begin
        chk("done_without_write", 32'(m_if.mem_write), 32'd0);
        if (exp_dn.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          dn_t e;
          e = exp_dn.pop_front();
          chk("word_count", 32'(word_count), 32'(e.wc));
          chk("overflow", 32'(overflow), 32'(e.ov));
`ifdef LOADER_CHECKSUM_EN
          chk("csum", 32'(csum), 32'(e.cs));
`endif
          if (e.lat) chk("done_after_last_write", 32'(cyc - last_wr_cyc), 32'd1);
        end
      end
    end
  end

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.a = a; e.d = d; e.be = be;
    exp_wr.push_back(e);
  endtask

  task automatic push_dn(input int wc, input logic ov, input logic [15:0] cs, input bit lat);
    dn_t e;
    e.wc = (AW+1)'(wc); e.ov = ov; e.cs = cs; e.lat = lat;
    exp_dn.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((busy || done) && n < 200);
    if (busy || done) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    wait_idle();
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams bytes back to back; optionally pulses start (base 0x100) alongside byte start_at.
  task automatic send(input bq_t bytes, input bit eop_last, input int start_at, output int cycles);
    logic rdy;
    cycles = 0;
    foreach (bytes[i]) begin
      s_if.in_data  = bytes[i];
      s_if.in_valid = 1'b1;
      s_if.in_eop   = eop_last && (i == bytes.size() - 1);
      start         = (i == start_at);
      if (i == start_at) base_addr = 13'h100;
      do begin
        @(negedge clk);
        rdy = s_if.in_ready;
        @(posedge clk); #1;
        cycles++;
      end while (!rdy && cycles < 1000);
    end
    start = 1'b0;
    s_if.in_valid = 1'b0;
    s_if.in_eop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    int  cyc_used;

    s_if.in_data = '0;
    s_if.in_valid = 1'b0;
    s_if.in_eop = 1'b0;

    // Reset values
    #3;
    chk("rst_clken", 32'(m_if.mem_clken), 32'd0);
    chk("rst_write", 32'(m_if.mem_write), 32'd0);
    chk("rst_in_ready", 32'(s_if.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    #19 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("clken_after_reset", 32'(m_if.mem_clken), 32'd1);

    // Bytes offered while idle are not accepted
    s_if.in_valid = 1'b1;
    s_if.in_data = 8'h5A;
    s_if.in_eop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(s_if.in_ready), 32'd0);
    end
    s_if.in_valid = 1'b0;
    s_if.in_eop = 1'b0;

    // Test 1: two full words
    push_wr(13'h010, 32'h0403_0201, 4'hF);
    push_wr(13'h011, 32'h0807_0605, 4'hF);
    push_dn(2, 1'b0, 16'h0024, 1'b1);
    do_start(13'h010);
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send(b, 1'b1, -1, cyc_used);
    chk("t1_throughput", 32'(cyc_used), 32'd8);

    // Test 2: eop on lane 0 of second word
    push_wr(13'h000, 32'h0403_0201, 4'hF);
    push_wr(13'h001, 32'h0000_0005, 4'h1);
    push_dn(2, 1'b0, 16'h000F, 1'b1);
    do_start(13'h000);
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send(b, 1'b1, -1, cyc_used);

    // Test 3: runs past the last RAM word
    push_wr(13'd6498, 32'h0403_0201, 4'hF);
    push_wr(13'd6499, 32'h0807_0605, 4'hF);
    push_dn(2, 1'b1, 16'h004E, 1'b0);
    do_start(13'd6498);
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
          8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    send(b, 1'b1, -1, cyc_used);
    chk("t3_all_accepted", 32'(cyc_used), 32'd12);

    // Test 3b: single byte at the last legal address
    push_wr(13'd6499, 32'h0000_00AB, 4'h1);
    push_dn(1, 1'b0, 16'h00AB, 1'b1);
    do_start(13'd6499);
    b = '{8'hAB};
    send(b, 1'b1, -1, cyc_used);

    // Test 4: start mid-load ignored; eop on lane 1
    push_wr(13'h040, 32'h4433_2211, 4'hF);
    push_wr(13'h041, 32'h0000_6655, 4'h3);
    push_dn(2, 1'b0, 16'h0165, 1'b1);
    do_start(13'h040);
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send(b, 1'b1, 2, cyc_used);

    // Test 5: reset in the middle of a load
    push_wr(13'h030, 32'h0403_0201, 4'hF);
    do_start(13'h030);
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(b, 1'b0, -1, cyc_used);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_word_count", 32'(word_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(s_if.in_ready), 32'd0);
    chk("mid_rst_clken", 32'(m_if.mem_clken), 32'd0);
    chk("mid_rst_address", 32'(m_if.mem_address), 32'd0);
    chk("mid_rst_writedata", m_if.mem_writedata, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    push_wr(13'h020, 32'hA4A3_A2A1, 4'hF);
    push_dn(1, 1'b0, 16'h028A, 1'b1);
    do_start(13'h020);
    b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send(b, 1'b1, -1, cyc_used);

`ifdef LOADER_CHECKSUM_EN
    // Test 6: checksum wraps into 16 bits and clears on start
    push_wr(13'h050, 32'hFFFF_FFFF, 4'hF);
    push_dn(1, 1'b0, 16'h03FC, 1'b1);
    do_start(13'h050);
    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send(b, 1'b1, -1, cyc_used);
    do_start(13'h060);
    chk("csum_cleared", 32'(csum), 32'd0);
    push_wr(13'h060, 32'h0000_0001, 4'h1);
    push_dn(1, 1'b0, 16'h0001, 1'b1);
    b = '{8'h01};
    send(b, 1'b1, -1, cyc_used);
`endif

    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    chk("dones_outstanding", 32'(exp_dn.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
